mem_arbiter: RTL and testbench

- Shares one single-port 32-bit memory between two requesters: instruction fetch (IF) and load/store data (D).
- Sits between the multi-cycle CPU core and the unified memory array.
- A 4-state FSM sequences each access and applies two-way round-robin arbitration on conflict.
- Read data is returned through registered response ports; writes complete at issue.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  function automatic logic [1:0] onehot_req(input req_id_t id);
    return (id == REQ_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer remembers the last granted requester.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output req_id_t    sel
);

  req_id_t last;

  always_comb begin
    sel = REQ_IF;
    case (req)
      2'b10:   sel = REQ_D;
      2'b11:   sel = (last == REQ_IF) ? REQ_D : REQ_IF;
      default: sel = REQ_IF;
    endcase
  end

  // Reset to "D granted last" so IF wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= REQ_D;
    end else if (update) begin
      last <= sel;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT out of range");
  end

  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

  state_t     state, state_nx;
  req_id_t    sel_id, arb_sel;
  logic [2:0] lat_cnt;
  logic [1:0] arb_req;
  logic       arb_update;
  logic       sel_held;

  assign sel_held = (sel_id == REQ_D) ? d_req : if_req;

  // In ISSUE the arbiter sees only the latched requester, so its pick equals
  // sel_id and the pointer update records the requester actually granted.
  assign arb_req    = (state == ISSUE) ? onehot_req(sel_id) : {d_req, if_req};
  assign arb_update = (state == ISSUE) && sel_held;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .update (arb_update),
    .sel    (arb_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (if_req || d_req) state_nx = ISSUE;
      end
      ISSUE: begin
        if (!sel_held) begin
          state_nx = IDLE;
        end else begin
          mem_en = 1'b1;
          if (sel_id == REQ_D) begin
            d_gnt    = 1'b1;
            mem_addr = d_addr;
            if (d_we) begin
              mem_we    = 1'b1;
              mem_wdata = d_wdata;
              state_nx  = IDLE;
            end else begin
              state_nx = WAIT;
            end
          end else begin
            if_gnt   = 1'b1;
            mem_addr = if_addr;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_CNT) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
        if (sel_id == REQ_D) d_rvalid = 1'b1;
        else                 if_rvalid = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_id   <= REQ_IF;
      lat_cnt  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) sel_id <= arb_sel;
        end
        ISSUE: lat_cnt <= 3'd1;
        WAIT: begin
          if (lat_cnt == LAT_CNT) begin
            if (sel_id == REQ_D) d_rdata  <= mem_rdata;
            else                 if_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 4) against a timeline model.
module tb_mem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;
  localparam int BIG  = 32'h3fffffff;

  logic clk, rst;
  logic [1:0] if_req, d_req, d_we;
  logic [11:0] if_addr [2];
  logic [11:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [1:0] if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata [2];
  logic [31:0] d_rdata [2];
  logic [11:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rdata(if_rdata[0]), .if_rvalid(if_rvalid[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rdata(d_rdata[0]), .d_rvalid(d_rvalid[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rdata(if_rdata[1]), .if_rvalid(if_rvalid[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rdata(d_rdata[1]), .d_rvalid(d_rvalid[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Memory environment: read data valid MEM_LAT cycles after mem_en, junk otherwise.
  logic [31:0] mem [2][4096];
  logic [31:0] pipe [2][4];
  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem[k][mem_addr[k]] : $urandom;
      if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k]] <= mem_wdata[k];
    end
  end

  // Reference model: transaction timeline derived from the latency rules.
  logic [31:0] ref_mem [2][4096];
  int  free_at [2];
  bit  pend [2];
  bit  pend_id [2];
  bit  last [2];
  int  rv_cyc [2];
  bit  rv_id [2];
  logic [31:0] rv_data [2];
  logic [31:0] exp_rd [2][2];
  bit  lg_if [2];
  bit  lg_d [2];
  int  gq0[$], gq1[$], rq0[$], rq1[$];

  logic [6:0]  ce;
  logic [11:0] ae;
  logic [31:0] wde;
  bit          w;
  int          lat;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ce = '0; ae = '0; wde = '0;
      lat = (k == 0) ? LAT0 : LAT1;
      if (!rst) begin
        free_at[k] = 0; pend[k] = 0; last[k] = 1; rv_cyc[k] = -1;
        exp_rd[k][0] = '0; exp_rd[k][1] = '0;
      end else begin
        ce[2] = (cyc < free_at[k]);
        if (pend[k]) begin
          pend[k] = 0;
          w = pend_id[k];
          if (w ? d_req[k] : if_req[k]) begin
            if (w) ce[5] = 1'b1; else ce[6] = 1'b1;
            ce[1] = 1'b1;
            last[k] = w;
            ae = w ? d_addr[k] : if_addr[k];
            if (w && d_we[k]) begin
              ce[0] = 1'b1;
              wde = d_wdata[k];
              ref_mem[k][ae] = wde;
              free_at[k] = cyc + 1;
            end else begin
              rv_cyc[k]  = cyc + lat + 1;
              rv_id[k]   = w;
              rv_data[k] = ref_mem[k][ae];
              free_at[k] = cyc + lat + 2;
            end
          end else begin
            free_at[k] = cyc + 1;
          end
        end else if (cyc >= free_at[k] && (if_req[k] || d_req[k])) begin
          pend_id[k] = (if_req[k] && d_req[k]) ? !last[k] : d_req[k];
          pend[k]    = 1;
          free_at[k] = BIG;
        end
        if (cyc == rv_cyc[k]) begin
          if (rv_id[k]) ce[3] = 1'b1; else ce[4] = 1'b1;
          exp_rd[k][rv_id[k]] = rv_data[k];
          rv_cyc[k] = -1;
        end
      end
      check("ctl{ig,dg,irv,drv,busy,en,we}", k,
            32'({if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], busy[k], mem_en[k], mem_we[k]}),
            32'(ce));
      check("mem_addr", k, 32'(mem_addr[k]), 32'(ae));
      check("mem_wdata", k, mem_wdata[k], wde);
      check("if_rdata", k, if_rdata[k], exp_rd[k][0]);
      check("d_rdata", k, d_rdata[k], exp_rd[k][1]);
      lg_if[k] = if_gnt[k];
      lg_d[k]  = d_gnt[k];
      if (k == 0) begin
        if (if_gnt[0]) gq0.push_back(0);
        if (d_gnt[0])  gq0.push_back(1);
        if (if_rvalid[0]) rq0.push_back(0);
        if (d_rvalid[0])  rq0.push_back(1);
      end else begin
        if (if_gnt[1]) gq1.push_back(0);
        if (d_gnt[1])  gq1.push_back(1);
        if (if_rvalid[1]) rq1.push_back(0);
        if (d_rvalid[1])  rq1.push_back(1);
      end
    end
  end

  typedef struct {
    int          inst;
    bit          is_d;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          gnt_off;
    int          rv_off;    // 0: no rvalid expected
    logic [31:0] rdata;
    int          idle_off;
  } row_t;

  row_t rows [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    if_req = '0; d_req = '0; d_we = '0;
  endtask

  int t, gc, rc, idc;
  logic gwe;
  logic [11:0] gaddr;
  logic [31:0] gwd, rd;

  initial begin
    rows[0] = '{0, 0, 0, 12'h010, 32'h0,        1, 3, 32'h8C220004, 4};
    rows[1] = '{0, 1, 1, 12'h004, 32'hDEADBEEF, 1, 0, 32'h0,        2};
    rows[2] = '{0, 1, 0, 12'h004, 32'h0,        1, 3, 32'hDEADBEEF, 4};
    rows[3] = '{0, 0, 0, 12'h004, 32'h0,        1, 3, 32'hDEADBEEF, 4};
    rows[4] = '{0, 1, 1, 12'hFFF, 32'h12345678, 1, 0, 32'h0,        2};
    rows[5] = '{0, 0, 0, 12'hFFF, 32'h0,        1, 3, 32'h12345678, 4};
    rows[6] = '{1, 1, 1, 12'h020, 32'hCAFEF00D, 1, 0, 32'h0,        2};
    rows[7] = '{1, 1, 0, 12'h020, 32'h0,        1, 6, 32'hCAFEF00D, 7};
    rows[8] = '{1, 0, 0, 12'h010, 32'h0,        1, 6, 32'h8C220004, 7};

    rst = 1'b0;
    drop_all();
    for (int k = 0; k < 2; k++) begin
      if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int a = 0; a < 4096; a++) begin
        mem[k][a]     = $urandom;
        ref_mem[k][a] = mem[k][a];
      end
      mem[k][12'h010]     = 32'h8C220004;
      ref_mem[k][12'h010] = 32'h8C220004;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // First conflict after reset, both held: IF, D, IF, D.
    gq0.delete(); rq0.delete();
    if_req[0] = 1; if_addr[0] = 12'h010;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 12'h011;
    for (int n = 0; n < 40 && gq0.size() < 4; n++) step();
    drop_all();
    for (int n = 0; n < 40 && rq0.size() < 4; n++) step();
    check("conflict_gnt_count", 0, 32'(gq0.size()), 32'd4);
    check("conflict_rv_count", 0, 32'(rq0.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq0.size(); i++) check("conflict_gnt_order", 0, 32'(gq0[i]), 32'(i % 2));
    for (int i = 0; i < 4 && i < rq0.size(); i++) check("conflict_rv_order", 0, 32'(rq0[i]), 32'(i % 2));
    repeat (6) step();

    // Isolated transactions with fixed expected timing and data.
    foreach (rows[r]) begin
      t = cyc; gc = -1; rc = -1; idc = -1; rd = '0;
      gwe = 1'b0; gaddr = '0; gwd = '0;
      if (rows[r].is_d) begin
        d_req[rows[r].inst] = 1; d_we[rows[r].inst] = rows[r].we;
        d_addr[rows[r].inst] = rows[r].addr; d_wdata[rows[r].inst] = rows[r].wdata;
      end else begin
        if_req[rows[r].inst] = 1; if_addr[rows[r].inst] = rows[r].addr;
      end
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if ((rows[r].is_d ? d_gnt[rows[r].inst] : if_gnt[rows[r].inst]) && gc < 0) begin
          gc = cyc; gwe = mem_we[rows[r].inst];
          gaddr = mem_addr[rows[r].inst]; gwd = mem_wdata[rows[r].inst];
        end
        if (rows[r].is_d ? d_rvalid[rows[r].inst] : if_rvalid[rows[r].inst]) begin
          rc = cyc;
          rd = rows[r].is_d ? d_rdata[rows[r].inst] : if_rdata[rows[r].inst];
        end
        if (gc >= 0 && idc < 0 && cyc > gc && !busy[rows[r].inst]) idc = cyc;
        step();
        if (gc >= 0) drop_all();
      end
      check("vec_gnt_off", r, 32'(gc - t), 32'(rows[r].gnt_off));
      check("vec_mem_we", r, 32'(gwe), 32'(rows[r].we));
      check("vec_mem_addr", r, 32'(gaddr), 32'(rows[r].addr));
      check("vec_mem_wdata", r, gwd, rows[r].we ? rows[r].wdata : 32'h0);
      check("vec_rv_off", r, 32'((rc < 0) ? 0 : rc - t), 32'(rows[r].rv_off));
      check("vec_rdata", r, rd, rows[r].rdata);
      check("vec_idle_off", r, 32'(idc - t), 32'(rows[r].idle_off));
    end

    // d_req withdrawn in ISSUE; last grant on inst0 was IF, so D must win next.
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 12'h030;
    @(negedge clk);
    step();
    d_req[0] = 0;
    @(negedge clk);
    check("drop_no_gnt", 0, 32'({d_gnt[0], mem_en[0]}), 32'd0);
    check("drop_busy_issue", 0, 32'(busy[0]), 32'd1);
    step();
    @(negedge clk);
    check("drop_idle_next", 0, 32'(busy[0]), 32'd0);
    step();
    gq0.delete();
    if_req[0] = 1; if_addr[0] = 12'h040;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 12'h041;
    for (int n = 0; n < 10 && gq0.size() == 0; n++) step();
    drop_all();
    check("drop_ptr_unchanged", 0, 32'((gq0.size() > 0) ? gq0[0] : 2), 32'd1);
    repeat (8) step();

    // Reset during WAIT of an IF read (inst1, MEM_LAT=4).
    gq1.delete(); rq1.delete();
    if_req[1] = 1; if_addr[1] = 12'h010;
    for (int n = 0; n < 10 && gq1.size() == 0; n++) step();
    drop_all();
    check("rst_pre_gnt", 1, 32'(gq1.size()), 32'd1);
    step();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_async_ctl", k,
            32'({if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], busy[k], mem_en[k], mem_we[k]}), 32'd0);
      check("rst_async_addr", k, 32'(mem_addr[k]), 32'd0);
      check("rst_async_wdata", k, mem_wdata[k], 32'd0);
      check("rst_async_if_rdata", k, if_rdata[k], 32'd0);
      check("rst_async_d_rdata", k, d_rdata[k], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rq1.delete();
    repeat (10) step();
    check("rst_no_rvalid", 1, 32'(rq1.size()), 32'd0);
    gq1.delete();
    if_req[1] = 1; if_addr[1] = 12'h012;
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 12'h013;
    for (int n = 0; n < 10 && gq1.size() == 0; n++) step();
    drop_all();
    check("rst_if_wins", 1, 32'((gq1.size() > 0) ? gq1[0] : 2), 32'd0);
    repeat (10) step();

    // Random traffic on both instances, checked cycle by cycle by the model.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (if_req[k] && lg_if[k]) if_req[k] = 0;
        else if (!if_req[k] && $urandom_range(0, 2) == 0) begin
          if_req[k] = 1; if_addr[k] = 12'($urandom_range(0, 15));
        end
        if (d_req[k] && lg_d[k]) begin
          d_req[k] = 0; d_we[k] = 0;
        end else if (!d_req[k] && $urandom_range(0, 2) == 0) begin
          d_req[k] = 1; d_we[k] = 1'($urandom_range(0, 1));
          d_addr[k] = 12'($urandom_range(0, 15)); d_wdata[k] = $urandom;
        end
      end
      step();
    end
    drop_all();
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
